egg_timer_countdown: RTL and testbench
======================================

Name: egg_timer_countdown

Overview:
- Countdown core of the egg timer. Consumes the single-cycle 1 Hz `tick` pulse produced by the slow-to-fast clock synchronizer on the `clkFast` domain.
- Holds a minutes:seconds setting and counts it down to 00:00, then raises an alarm for a fixed number of ticks.
- Button inputs arrive already debounced and edge-detected, one `clkFast` cycle wide.
- Outputs feed the display driver and the buzzer.

Parameters:
- MAX_MIN, 99, largest settable minutes value; `btnMin` wraps from MAX_MIN to 0.
- ALARM_TICKS, 10, number of `tick` pulses the alarm stays asserted before auto-return to IDLE.

Ports:
- clkFast  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  1 Hz pulse, high for exactly one clkFast cycle.
- btnMin  input  1  one-cycle pulse: increment minutes.
- btnSec  input  1  one-cycle pulse: increment seconds.
- btnStartStop  input  1  one-cycle pulse: start / pause / resume.
- btnClear  input  1  one-cycle pulse: zero time, go IDLE.
- minutes  output  7  current minutes, 0..MAX_MIN, registered.
- seconds  output  6  current seconds, 0..59, registered.
- running  output  1  high in RUN, registered.
- alarm  output  1  high in ALARM, registered.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, minutes=0, seconds=0, running=0, alarm=0, alarm counter=0. Outputs stay at these values while reset is low.
- States: IDLE, RUN, PAUSE, ALARM. Encoding is free. `running` = (state==RUN); `alarm` = (state==ALARM).
- All outputs are registered. The effect of an input sampled at edge N is visible after edge N.
- Priority within one cycle: btnClear > btnStartStop > tick > btnMin/btnSec.
- btnClear (any state): minutes=0, seconds=0, state=IDLE, alarm counter cleared.
- IDLE and PAUSE:
  - btnMin: minutes = (minutes==MAX_MIN) ? 0 : minutes+1.
  - btnSec: seconds = (seconds==59) ? 0 : seconds+1. No carry into minutes.
  - btnMin and btnSec in the same cycle: both apply.
  - tick: ignored.
  - btnStartStop with time==00:00: ignored, stay in state.
  - btnStartStop with time!=00:00: go to RUN.
- RUN:
  - btnStartStop: go to PAUSE. A tick in the same cycle is dropped.
  - btnMin and btnSec: ignored.
  - tick with seconds>0: seconds-1.
  - tick with seconds==0 and minutes>0: minutes-1, seconds=59.
  - If a tick's decrement produces 00:00, next state is ALARM on that same edge. So 00:01 plus one tick gives 00:00 with alarm=1 together.
  - Latency from start to first decrement equals the wait for the next tick. No partial-second correction.
- ALARM:
  - Time holds at 00:00.
  - Each tick increments the alarm counter. On the tick that makes the count reach ALARM_TICKS, go to IDLE with alarm=0.
  - Any btnStartStop, btnMin or btnSec: go to IDLE and clear the counter. That button's own increment is not applied.
  - On exit, the alarm counter returns to 0.
- Counter widths:
  - The alarm counter is wide enough for ALARM_TICKS.
  - No arithmetic may overflow past the stated ranges.
- Reset mid-RUN or mid-ALARM: immediate return to reset values, with no glitch pulse on `alarm`.

Test Plan:
- Reset, then 3×btnMin, 5×btnSec, btnStartStop, 5 ticks -> after each tick 03:04, 03:03, 03:02, 03:01, 03:00; running=1 throughout.
- Set 01:00, run, 1 tick -> 00:59 (borrow). Set 00:01, run, 1 tick -> 00:00 with alarm=1 and running=0 in the same cycle. Then 10 ticks -> alarm drops on the 10th, state IDLE.
- btnStartStop at 00:00 in IDLE -> running stays 0. Then 100×btnMin -> minutes wraps to 0 after the 100th. 60×btnSec -> seconds 0, minutes unchanged.
- Running at 02:10: btnStartStop and tick in the same cycle -> PAUSE, time stays 02:10. Further ticks give no change. btnStartStop -> RUN resumes from 02:10.
- In ALARM: btnSec -> IDLE, alarm=0, seconds stays 0. In RUN: btnClear together with tick -> 00:00, IDLE, alarm never asserts.
- Assert reset low asynchronously (mid-cycle) during RUN at 05:30 -> outputs 00:00, running=0, alarm=0 before the next clock edge. Release, then tick -> no change.

Source files
------------

// File: rtl/egg_timer_countdown.sv
// Egg timer countdown core: minutes:seconds setting, 1 Hz countdown, timed alarm.
// All outputs are registered and change only on clkFast rising edges.
module egg_timer_countdown #(
    parameter int MAX_MIN     = 99,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clkFast,
    input  logic       reset,
    input  logic       tick,
    input  logic       btnMin,
    input  logic       btnSec,
    input  logic       btnStartStop,
    input  logic       btnClear,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       alarm
);

    localparam int CW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] ALARM = 2'd3;

    localparam logic [6:0]    MIN_TOP  = 7'(MAX_MIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(ALARM_TICKS - 1);

    logic [1:0]    state, state_d;
    logic [6:0]    min_d;
    logic [5:0]    sec_d;
    logic [CW-1:0] alarm_cnt, cnt_d;
    logic          time_zero;

    assign time_zero = (minutes == 7'd0) && (seconds == 6'd0);

    always_comb begin
        state_d = state;
        min_d   = minutes;
        sec_d   = seconds;
        cnt_d   = alarm_cnt;
        if (btnClear) begin
            state_d = IDLE;
            min_d   = '0;
            sec_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (btnStartStop) begin
                        if (!time_zero) state_d = RUN;
                    end else begin
                        if (btnMin) min_d = (minutes == MIN_TOP) ? '0 : minutes + 7'd1;
                        if (btnSec) sec_d = (seconds == 6'd59) ? '0 : seconds + 6'd1;
                    end
                end
                RUN: begin
                    if (btnStartStop) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (seconds != 6'd0) begin
                            sec_d = seconds - 6'd1;
                            // Reaching 00:00 enters ALARM on the same edge as the decrement
                            if (seconds == 6'd1 && minutes == 7'd0) begin
                                state_d = ALARM;
                                cnt_d   = '0;
                            end
                        end else if (minutes != 7'd0) begin
                            min_d = minutes - 7'd1;
                            sec_d = 6'd59;
                        end
                    end
                end
                ALARM: begin
                    if (btnStartStop || btnMin || btnSec) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (alarm_cnt == CNT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = alarm_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Flags are registered from the next state so they stay aligned with it
    always_ff @(posedge clkFast or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            minutes   <= '0;
            seconds   <= '0;
            alarm_cnt <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_d;
            minutes   <= min_d;
            seconds   <= sec_d;
            alarm_cnt <= cnt_d;
            running   <= (state_d == RUN);
            alarm     <= (state_d == ALARM);
        end
    end

endmodule

// File: tb/tb_egg_timer_countdown.sv
// Bench for egg_timer_countdown: directed scenarios plus random button/tick traffic,
// checked against a total-seconds reference model.
module tb_egg_timer_countdown;

    localparam int MAX_MIN     = 99;
    localparam int ALARM_TICKS = 10;

    logic       clkFast = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       btnMin = 1'b0;
    logic       btnSec = 1'b0;
    logic       btnStartStop = 1'b0;
    logic       btnClear = 1'b0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       alarm;

    int compared = 0;
    int mismatched = 0;

    // Reference model: time, plus "counting" / "ringing" flags and ticks heard while ringing
    int m_min = 0;
    int m_sec = 0;
    bit m_run = 1'b0;
    bit m_alm = 1'b0;
    int m_rung = 0;

    egg_timer_countdown #(.MAX_MIN(MAX_MIN), .ALARM_TICKS(ALARM_TICKS)) dut (
        .clkFast(clkFast), .reset(reset), .tick(tick), .btnMin(btnMin), .btnSec(btnSec),
        .btnStartStop(btnStartStop), .btnClear(btnClear),
        .minutes(minutes), .seconds(seconds), .running(running), .alarm(alarm)
    );

    always #5 clkFast = ~clkFast;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".minutes"}, 32'(minutes), m_min);
        check({tag, ".seconds"}, 32'(seconds), m_sec);
        check({tag, ".running"}, 32'(running), 32'(m_run));
        check({tag, ".alarm"},   32'(alarm),   32'(m_alm));
    endtask

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_run = 0; m_alm = 0; m_rung = 0;
    endtask

    task automatic model_step(input bit clr, input bit ss, input bit tk, input bit bm, input bit bs);
        int total;
        total = m_min * 60 + m_sec;
        if (clr) begin
            model_reset();
        end else if (m_alm) begin
            if (ss || bm || bs) begin
                m_alm = 0; m_rung = 0;
            end else if (tk) begin
                m_rung++;
                if (m_rung == ALARM_TICKS) begin
                    m_alm = 0; m_rung = 0;
                end
            end
        end else if (m_run) begin
            if (ss) begin
                m_run = 0;
            end else if (tk) begin
                total = total - 1;
                m_min = total / 60;
                m_sec = total % 60;
                if (total == 0) begin
                    m_run = 0; m_alm = 1; m_rung = 0;
                end
            end
        end else begin
            if (ss) begin
                if (total != 0) m_run = 1;
            end else begin
                if (bm) m_min = (m_min + 1) % (MAX_MIN + 1);
                if (bs) m_sec = (m_sec + 1) % 60;
            end
        end
    endtask

    task automatic step(input string tag, input bit clr, input bit ss, input bit tk,
                        input bit bm, input bit bs);
        btnClear = clr; btnStartStop = ss; tick = tk; btnMin = bm; btnSec = bs;
        @(posedge clkFast);
        #1;
        btnClear = 0; btnStartStop = 0; tick = 0; btnMin = 0; btnSec = 0;
        model_step(clr, ss, tk, bm, bs);
        check_all(tag);
    endtask

    task automatic set_time(input int mins, input int secs);
        for (int i = 0; i < mins; i++) step("set_min", 0, 0, 0, 1, 0);
        for (int i = 0; i < secs; i++) step("set_sec", 0, 0, 0, 0, 1);
    endtask

    initial begin
        #12;
        model_reset();
        check_all("reset");
        #1 reset = 1'b1;
        @(posedge clkFast); #1;
        check_all("post_reset");

        // 03:05 countdown
        set_time(3, 5);
        step("start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("cd_tick", 0, 0, 1, 0, 0);
            check("cd_running", 32'(running), 32'd1);
        end
        check("cd_end_min", 32'(minutes), 32'd3);
        check("cd_end_sec", 32'(seconds), 32'd0);
        step("cd_tick_borrow", 0, 0, 1, 0, 0);
        check("borrow_sec", 32'(seconds), 32'd59);
        step("clear", 1, 0, 0, 0, 0);

        // 01:00 borrow, then 00:01 to alarm and timed auto-return
        set_time(1, 0);
        step("start", 0, 1, 0, 0, 0);
        step("tick_0100", 0, 0, 1, 0, 0);
        check("b100_min", 32'(minutes), 32'd0);
        check("b100_sec", 32'(seconds), 32'd59);
        step("clear", 1, 0, 0, 0, 0);
        set_time(0, 1);
        step("start", 0, 1, 0, 0, 0);
        step("tick_to_alarm", 0, 0, 1, 0, 0);
        check("alarm_set", 32'(alarm), 32'd1);
        for (int i = 0; i < ALARM_TICKS; i++) step("alarm_tick", 0, 0, 1, 0, 0);
        check("alarm_dropped", 32'(alarm), 32'd0);

        // start at 00:00 ignored, minute/second wraps
        step("start_zero", 0, 1, 0, 0, 0);
        check("start_zero_run", 32'(running), 32'd0);
        set_time(MAX_MIN + 1, 0);
        check("min_wrap", 32'(minutes), 32'd0);
        step("one_min", 0, 0, 0, 1, 0);
        set_time(0, 60);
        check("sec_wrap", 32'(seconds), 32'd0);
        check("sec_wrap_min", 32'(minutes), 32'd1);
        step("both_btn", 0, 0, 0, 1, 1);
        step("clear", 1, 0, 0, 0, 0);

        // pause with simultaneous tick, then resume
        set_time(2, 10);
        step("start", 0, 1, 0, 0, 0);
        step("pause_with_tick", 0, 1, 1, 0, 0);
        check("pause_sec", 32'(seconds), 32'd10);
        for (int i = 0; i < 3; i++) step("paused_tick", 0, 0, 1, 0, 0);
        step("paused_btn", 0, 0, 0, 1, 0);
        step("resume", 0, 1, 0, 0, 0);
        step("resume_tick", 0, 0, 1, 0, 0);
        step("run_btn_ignored", 0, 0, 0, 1, 1);
        step("clear", 1, 0, 0, 0, 0);

        // leave alarm with btnSec; clear wins over tick in RUN
        set_time(0, 1);
        step("start", 0, 1, 0, 0, 0);
        step("tick_to_alarm", 0, 0, 1, 0, 0);
        step("alarm_btnsec", 0, 0, 0, 0, 1);
        check("alarm_exit_sec", 32'(seconds), 32'd0);
        set_time(0, 1);
        step("start", 0, 1, 0, 0, 0);
        step("clear_with_tick", 1, 0, 1, 0, 0);

        // asynchronous reset mid-cycle during RUN at 05:30
        set_time(5, 30);
        step("start", 0, 1, 0, 0, 0);
        step("run_tick", 0, 0, 1, 0, 0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #2 reset = 1'b1;
        step("tick_after_reset", 0, 0, 1, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
